// File: rtl/ha_array_pkg.sv
// Shared widths, FSM state encoding and the row record for the ha_array accumulator.
package ha_array_pkg;

  localparam int HA_ROWS   = 4;
  localparam int HA_B_W    = 7;
  localparam int HA_T_W    = 9;
  localparam int HA_ROW_W  = 10;
  localparam int HA_PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } ha_acc_state_t;

  typedef struct packed {
    logic [HA_B_W-1:0] b;
    logic [HA_T_W-1:0] t;
  } ha_row_t;

endpackage

// File: rtl/ha_array_accumulator_row_value.sv
// Combinational value of one half-adder partial-product row: r = t + (b << 2).
module ha_row_value
  import ha_array_pkg::*;
(
  input  logic [HA_B_W-1:0]   b,
  input  logic [HA_T_W-1:0]   t,
  output logic [HA_ROW_W-1:0] r
);

  // Both operands are at most 9 bits, so the 10-bit sum cannot overflow.
  assign r = {1'b0, t} + {1'b0, b, 2'b00};

endmodule

// File: rtl/ha_array_accumulator.sv
// Iterative four-row accumulator behind the ha_array multiplier generators.
// Optional build macro HA_ACC_COMP_EN adds a saturating bias (COMP_BIAS) to the result.
module ha_array_accumulator
  import ha_array_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HA_B_W-1:0]    ha_array_0_b,
  input  logic [HA_B_W-1:0]    ha_array_1_b,
  input  logic [HA_B_W-1:0]    ha_array_2_b,
  input  logic [HA_B_W-1:0]    ha_array_3_b,
  input  logic [HA_T_W-1:0]    ha_array_0_t,
  input  logic [HA_T_W-1:0]    ha_array_1_t,
  input  logic [HA_T_W-1:0]    ha_array_2_t,
  input  logic [HA_T_W-1:0]    ha_array_3_t,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HA_PROD_W-1:0] product
);

`ifdef HA_ACC_COMP_EN
  // Only the compensated build has a bias to configure.
  parameter logic [HA_PROD_W-1:0] COMP_BIAS = 16'd128;
`endif

  ha_acc_state_t          state_q;
  logic [1:0]             rc_q;
  logic [HA_PROD_W-1:0]   acc_q;
  logic [HA_PROD_W-1:0]   prod_q;
  ha_row_t                rows_q [HA_ROWS];

  ha_row_t                row_sel;
  logic [HA_ROW_W-1:0]    row_val;
  logic [HA_PROD_W-1:0]   contrib;
  logic [HA_PROD_W-1:0]   acc_next;
  logic [HA_PROD_W-1:0]   prod_load;

  assign row_sel = rows_q[rc_q];

  ha_row_value u_row_value (
    .b (row_sel.b),
    .t (row_sel.t),
    .r (row_val)
  );

  assign contrib  = {6'd0, row_val} << {rc_q, 1'b0};
  assign acc_next = acc_q + contrib;

`ifdef HA_ACC_COMP_EN
  // Bias is applied after the modulo-2^16 wrap of the row sum.
  logic [HA_PROD_W:0] biased;
  assign biased    = {1'b0, acc_next} + {1'b0, COMP_BIAS};
  assign prod_load = biased[HA_PROD_W] ? {HA_PROD_W{1'b1}} : biased[HA_PROD_W-1:0];
`else
  assign prod_load = acc_next;
`endif

  // Row sets are only captured on the IDLE accept edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      rows_q[0] <= {ha_array_0_b, ha_array_0_t};
      rows_q[1] <= {ha_array_1_b, ha_array_1_t};
      rows_q[2] <= {ha_array_2_b, ha_array_2_t};
      rows_q[3] <= {ha_array_3_b, ha_array_3_t};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= 2'd0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q   <= '0;
            rc_q    <= 2'd0;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_next;
          rc_q  <= rc_q + 2'd1;
          if (rc_q == 2'd3) begin
            prod_q  <= prod_load;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule
